hall_sensor_conditioner: RTL and testbench



---
 rtl/hall_sensor_conditioner_if.sv | 53 +++++
 rtl/hall_sensor_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_hall_sensor_conditioner.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hall_sensor_conditioner_if.sv
// -----------------------------------------------------------------------------
// hall_sensor_conditioner_if
//
// Purpose:
//   Bundles the Hall-sensor conditioner's data signals. The raw sensor code
//   enters here, and the conditioned commutation code and motion
//   measurements leave here.
//
// Modports:
//   master : the conditioner. It consumes hall_raw and drives every
//            measurement output.
//   slave  : the environment (sensor side plus phase driver / speed loop).
//            It drives hall_raw and observes the outputs.
//
// Signals:
//   hall_raw      3             asynchronous Hall inputs {C,B,A}
//   hall_out      3             debounced commutation code
//   hall_valid    1             hall_out is neither 000 nor 111
//   hall_fault    1             sticky invalid/skipped-step indicator
//   seq_error     1             one-cycle pulse on a skipped-step transition
//   direction     1             1 = forward, 0 = reverse
//   step_count    COUNT_WIDTH   signed step count, wraps
//   period        PERIOD_WIDTH  cycles between the last two same-direction steps
//   period_valid  1             one-cycle strobe when period updates
//   stalled       1             no adjacent step for 2^PERIOD_WIDTH-1 cycles
// -----------------------------------------------------------------------------
interface hall_sensor_conditioner_if #(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
);
    logic [2:0]              hall_raw;
    logic [2:0]              hall_out;
    logic                    hall_valid;
    logic                    hall_fault;
    logic                    seq_error;
    logic                    direction;
    logic [COUNT_WIDTH-1:0]  step_count;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    stalled;

    modport master (
        input  hall_raw,
        output hall_out, hall_valid, hall_fault, seq_error, direction,
               step_count, period, period_valid, stalled
    );

    modport slave (
        output hall_raw,
        input  hall_out, hall_valid, hall_fault, seq_error, direction,
               step_count, period, period_valid, stalled
    );
endinterface

// File: rtl/hall_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// hall_sensor_conditioner
//
// Purpose:
//   This block is the front end of the BLDC phase driver. It synchronises the
//   three raw Hall inputs and debounces them. It then publishes a clean
//   commutation code and classifies every accepted code change as forward,
//   reverse, skipped or invalid. From those classifications it maintains a
//   signed step count, the direction, an inter-step period and a stall flag.
//
// Ports:
//   clock    in   system clock, all state changes on the rising edge
//   reset_n  in   synchronous active-low reset
//   bus      hall_sensor_conditioner_if.master (see the interface header)
//
// Parameters:
//   FILTER_CYCLES  consecutive synchronised cycles a new code must hold (>= 1)
//   COUNT_WIDTH    width of the signed step counter
//   PERIOD_WIDTH   width of the period measurement and stall counter
//
// Timing:
//   A steady raw change appears on hall_out FILTER_CYCLES+3 rising edges after
//   the first edge that samples it. That is two synchroniser stages, one
//   candidate load, and FILTER_CYCLES-1 further matching cycles before the
//   accepting edge.
// -----------------------------------------------------------------------------
module hall_sensor_conditioner #(
    parameter int FILTER_CYCLES = 16,
    parameter int COUNT_WIDTH   = 16,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    hall_sensor_conditioner_if.master bus
);

    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
    // The stable counter saturates at FILTER_CYCLES-1. Acceptance happens on
    // the edge that observes the FILTER_CYCLES-th consecutive match.
    localparam logic [FILT_W-1:0]       FILT_LAST  = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

    // Synchroniser and debounce state.
    logic [2:0]              sync1;
    logic [2:0]              sync2;
    logic [2:0]              candidate;
    logic [FILT_W-1:0]       stable_cnt;

    // Published state.
    logic [2:0]              hall_out_q;
    logic                    hall_valid_q;
    logic                    hall_fault_q;
    logic                    seq_error_q;
    logic                    direction_q;
    logic [COUNT_WIDTH-1:0]  step_count_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    period_valid_q;
    logic                    stalled_q;
    logic [PERIOD_WIDTH-1:0] period_cnt;

    // Successor of a code in the forward commutation sequence:
    // 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'b101:  return 3'b100;
            3'b100:  return 3'b110;
            3'b110:  return 3'b010;
            3'b010:  return 3'b011;
            3'b011:  return 3'b001;
            3'b001:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Acceptance uses the registered candidate. A raw change arriving on the
    // accepting cycle is still in the synchroniser and only restarts
    // filtering afterwards.
    logic accept;
    logic new_legal;
    logic both_legal;
    logic step_fwd;
    logic step_rev;
    logic step_adj;
    logic step_skip;
    logic code_bad;
    logic period_update;
    logic [PERIOD_WIDTH-1:0] elapsed;

    assign accept     = (sync2 == candidate) && (stable_cnt == FILT_LAST)
                        && (candidate != hall_out_q);
    assign new_legal  = is_legal(candidate);
    // An illegal old code (including 000 after reset) never counts,
    // faults or measures.
    assign both_legal = accept && hall_valid_q && new_legal;
    assign step_fwd   = both_legal && (fwd_next(hall_out_q) == candidate);
    assign step_rev   = both_legal && (fwd_next(candidate) == hall_out_q);
    assign step_adj   = step_fwd || step_rev;
    assign step_skip  = both_legal && !step_adj;
    assign code_bad   = accept && !new_legal;

    // A period is only meaningful between two consecutive steps in the same
    // direction with no stall in between.
    assign period_update = step_adj && !stalled_q && (step_fwd == direction_q);
    // The counter is zero on the edge after a step. At the next step it
    // therefore holds one less than the number of edges between the updates.
    assign elapsed = period_cnt + PERIOD_WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1          <= 3'b000;
            sync2          <= 3'b000;
            candidate      <= 3'b000;
            stable_cnt     <= '0;
            hall_out_q     <= 3'b000;
            hall_valid_q   <= 1'b0;
            hall_fault_q   <= 1'b0;
            seq_error_q    <= 1'b0;
            direction_q    <= 1'b1;
            step_count_q   <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
            period_cnt     <= '0;
        end else begin
            sync1 <= bus.hall_raw;
            sync2 <= sync1;

            if (sync2 != candidate) begin
                candidate  <= sync2;
                stable_cnt <= '0;
            end else if (stable_cnt != FILT_LAST) begin
                stable_cnt <= stable_cnt + FILT_W'(1);
            end

            if (accept) begin
                hall_out_q   <= candidate;
                hall_valid_q <= new_legal;
            end

            seq_error_q    <= step_skip;
            period_valid_q <= period_update;

            if (step_skip || code_bad) begin
                hall_fault_q <= 1'b1;
            end

            if (step_adj) begin
                direction_q  <= step_fwd;
                step_count_q <= step_fwd ? step_count_q + COUNT_WIDTH'(1)
                                         : step_count_q - COUNT_WIDTH'(1);
            end

            if (period_update) begin
                period_q <= elapsed;
            end

            // Only adjacent steps restart the timer. Skips and illegal codes
            // leave both the timer and the stall flag alone.
            if (step_adj) begin
                period_cnt <= '0;
                stalled_q  <= 1'b0;
            end else if (period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + PERIOD_WIDTH'(1);
                if (period_cnt == PERIOD_MAX - PERIOD_WIDTH'(1)) begin
                    stalled_q <= 1'b1;
                end
            end
        end
    end

    assign bus.hall_out     = hall_out_q;
    assign bus.hall_valid   = hall_valid_q;
    assign bus.hall_fault   = hall_fault_q;
    assign bus.seq_error    = seq_error_q;
    assign bus.direction    = direction_q;
    assign bus.step_count   = step_count_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.stalled      = stalled_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_hall_sensor_conditioner
//
// Purpose:
//   Self-checking bench for hall_sensor_conditioner with FILTER_CYCLES=4,
//   COUNT_WIDTH=4 and PERIOD_WIDTH=8. The stimulus thread drives raw codes
//   with chosen hold times. A behavioural model predicts every hall_out
//   update, including its edge, code, count and period, and pushes the
//   prediction into a queue. An independent monitor pops one entry per
//   observed hall_out change and compares it. Level checks cover reset
//   values and the exact stall threshold.
// -----------------------------------------------------------------------------
module tb_hall_sensor_conditioner;

    localparam int F    = 4;
    localparam int CW   = 4;
    localparam int PW   = 8;
    localparam int MAXP = (1 << PW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    hall_sensor_conditioner_if #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) bus ();

    hall_sensor_conditioner #(
        .FILTER_CYCLES(F),
        .COUNT_WIDTH  (CW),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int              cyc;
        logic [2:0]      code;
        logic            valid;
        logic            fault;
        logic            seq_err;
        logic            dir;
        logic [CW-1:0]   count;
        logic            pv;
        logic [PW-1:0]   period;
        logic            stalled;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         fwd_seq [6] = '{5, 4, 6, 2, 3, 1};
    logic [2:0] m_code;
    bit         m_fault;
    bit         m_dir;
    bit         m_have;     // an adjacent step happened since reset
    int         m_count;
    int         m_last;     // update edge of the last adjacent step
    int         m_period;

    function automatic bit legal(input logic [2:0] c);
        return (c != 3'd0) && (c != 3'd7);
    endfunction

    function automatic int seq_pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (fwd_seq[i] == int'(c)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_code = 3'd0; m_fault = 0; m_dir = 1; m_have = 0;
        m_count = 0; m_last = 0; m_period = 0;
    endtask

    task automatic model_update(input logic [2:0] code, input int u);
        exp_t e;
        bit   fwd, rev;
        e.cyc = u; e.code = code; e.valid = legal(code);
        e.seq_err = 0; e.pv = 0;
        if (!legal(code)) begin
            m_fault = 1;
        end else if (legal(m_code)) begin
            fwd = seq_pos(code) == (seq_pos(m_code) + 1) % 6;
            rev = seq_pos(code) == (seq_pos(m_code) + 5) % 6;
            if (fwd || rev) begin
                if (m_have && (u - m_last) <= MAXP && fwd == m_dir) begin
                    m_period = u - m_last;
                    e.pv = 1;
                end
                m_count = fwd ? m_count + 1 : m_count - 1;
                m_dir   = fwd;
                m_have  = 1;
                m_last  = u;
            end else begin
                e.seq_err = 1;
                m_fault   = 1;
            end
        end
        e.fault   = m_fault;
        e.dir     = m_dir;
        e.count   = m_count[CW-1:0];
        e.period  = m_period[PW-1:0];
        e.stalled = !m_have || (u - m_last >= MAXP);
        m_code    = code;
        sb.push_back(e);
    endtask

    // Drive code at a falling edge and keep it for 'hold' sampling edges.
    // The change reaches hall_out F+3 edges after the drive point, but only
    // if it lasted at least F+1 samples and differs from the current code.
    task automatic apply(input logic [2:0] code, input int hold);
        @(negedge clock);
        bus.hall_raw = code;
        if (hold >= F + 1 && code != m_code) model_update(code, cyc + F + 3);
        repeat (hold - 1) @(negedge clock);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_hall_out",     bus.hall_out,     0);
        check("rst_hall_valid",   bus.hall_valid,   0);
        check("rst_hall_fault",   bus.hall_fault,   0);
        check("rst_seq_error",    bus.seq_error,    0);
        check("rst_direction",    bus.direction,    1);
        check("rst_step_count",   bus.step_count,   0);
        check("rst_period",       bus.period,       0);
        check("rst_period_valid", bus.period_valid, 0);
        check("rst_stalled",      bus.stalled,      1);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [2:0] prev;
        exp_t       e;
        prev = 3'b000;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                prev = 3'b000;
            end else if (bus.hall_out !== prev) begin
                prev = bus.hall_out;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got code %0h with nothing expected at cycle %0d",
                             bus.hall_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("update_cycle", cyc,              e.cyc);
                    check("hall_out",     bus.hall_out,     e.code);
                    check("hall_valid",   bus.hall_valid,   e.valid);
                    check("hall_fault",   bus.hall_fault,   e.fault);
                    check("seq_error",    bus.seq_error,    e.seq_err);
                    check("direction",    bus.direction,    e.dir);
                    check("step_count",   bus.step_count,   e.count);
                    check("period_valid", bus.period_valid, e.pv);
                    check("period",       bus.period,       e.period);
                    check("stalled",      bus.stalled,      e.stalled);
                end
            end else begin
                check("stray_pulse", {30'd0, bus.seq_error, bus.period_valid}, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [2:0] fwd_list [7];
        logic [2:0] code;
        logic [2:0] g;
        int         p, r;

        fwd_list = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
        bus.hall_raw = 3'b000;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_values();
        reset_n = 1'b1;

        // First code from the post-reset 000: no count, no fault.
        apply(3'b101, 20);
        // A 4-cycle pulse is rejected, but a 5-cycle pulse is accepted.
        apply(3'b100, F);
        apply(3'b101, 30);
        apply(3'b100, F + 1);
        apply(3'b100, 100 - (F + 1));
        // Forward run with 100-cycle spacing. The count reaches 7 and then
        // wraps to -8 in 4 bits.
        foreach (fwd_list[i]) apply(fwd_list[i], 100);
        // Reverse twice. The reversal step gives no strobe; the second does.
        apply(3'b100, 60);
        apply(3'b101, 60);
        // Skipped step, then the two illegal codes, then re-entry.
        apply(3'b110, 40);
        apply(3'b111, 30);
        apply(3'b000, 30);
        apply(3'b011, 30);
        // One adjacent step, then hold until the stall threshold.
        apply(3'b001, F + 1);
        wait_until(m_last + MAXP - 1);
        check("stall_threshold_minus1", bus.stalled, 0);
        wait_until(m_last + MAXP);
        check("stall_threshold", bus.stalled, 1);
        apply(3'b101, 50);    // first step after stall: no strobe
        apply(3'b100, 50);    // period 50 with strobe
        apply(3'b100, F + 10);

        // Reset in the middle of filtering a new code.
        @(negedge clock);
        bus.hall_raw = 3'b110;
        repeat (3) @(negedge clock);
        reset_n      = 1'b0;
        bus.hall_raw = 3'b000;
        @(negedge clock);
        check_reset_values();
        reset_n = 1'b1;
        model_reset();
        repeat (F + 8) @(negedge clock);
        check("post_reset_idle", bus.hall_out, 0);

        // Randomised phase.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            p = seq_pos(m_code);
            if (!legal(m_code)) begin
                code = 3'(fwd_seq[$urandom_range(0, 5)]);
            end else if (r < 60) begin
                code = ($urandom_range(0, 1) == 1) ? 3'(fwd_seq[(p + 1) % 6])
                                                   : 3'(fwd_seq[(p + 5) % 6]);
            end else if (r < 72) begin
                code = 3'(fwd_seq[(p + $urandom_range(2, 4)) % 6]);
            end else if (r < 80) begin
                code = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            end else if (r < 92) begin
                do g = 3'($urandom_range(0, 7)); while (g == m_code);
                apply(g, $urandom_range(1, F));
                code = m_code;
            end else begin
                code = m_code;
            end
            apply(code, $urandom_range(F + 1, F + 40));
        end

        repeat (F + 10) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
